mod_sq_iter_ctrl: RTL and testbench



---
 rtl/mod_sq_iter_ctrl.sv | 136 +++++++++++++
 tb/tb_mod_sq_iter_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_sq_iter_ctrl.sv
// ----------------------------------------------------------------------------
// mod_sq_iter_ctrl
//
// Iteration controller for the VDF repeated-squaring loop. It wraps a modular
// multiplier (accum_mult_mod): a starting residue x is fed into both
// multiplier operands, and each product is captured and fed back as the next
// operand. After T squarings the block presents x^(2^T) mod MODULUS on a
// valid/ready result port. Only one multiplication is ever outstanding.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_val / o_rdy           start handshake (o_rdy high only when idle)
//   i_dat, i_iter           starting residue x and squaring count T
//   o_val / i_rdy / o_dat   result handshake and result x^(2^T) mod MODULUS
//   o_busy                  high while a squaring is issued or awaited
//   o_iter_left             squarings still to do (0 outside ISSUE/WAIT)
//   o_mul_val / i_mul_rdy   operand handshake towards the multiplier
//   o_mul_dat_a/_b          multiplier operands, both equal to current x
//   i_mul_val / o_mul_rdy   result handshake from the multiplier
//   i_mul_dat               multiplier product
//
// All outputs are decoded from registered state only, so there is no
// combinational path from any input to any output.
// ----------------------------------------------------------------------------
module mod_sq_iter_ctrl #(
    parameter int BITS   = 392,
    parameter int ITER_W = 40
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_val,
    output logic              o_rdy,
    input  logic [BITS-1:0]   i_dat,
    input  logic [ITER_W-1:0] i_iter,
    output logic              o_val,
    input  logic              i_rdy,
    output logic [BITS-1:0]   o_dat,
    output logic              o_busy,
    output logic [ITER_W-1:0] o_iter_left,
    output logic              o_mul_val,
    input  logic              i_mul_rdy,
    output logic [BITS-1:0]   o_mul_dat_a,
    output logic [BITS-1:0]   o_mul_dat_b,
    input  logic              i_mul_val,
    output logic              o_mul_rdy,
    input  logic [BITS-1:0]   i_mul_dat
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [BITS-1:0]   x_q, x_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of its neighbours; blocking assignments here would make
    // the result depend on statement order.
    // The residue register is reset as well because the reset value of o_dat
    // and of the operand buses is required to be zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: every signal written in this block gets a default first, so no
        // path through the case statement can leave one unassigned and infer
        // a latch.
        state_d     = state_q;
        x_d         = x_q;
        cnt_d       = cnt_q;
        o_rdy       = 1'b0;
        o_val       = 1'b0;
        o_busy      = 1'b0;
        o_mul_val   = 1'b0;
        o_mul_rdy   = 1'b0;
        o_iter_left = '0;

        unique case (state_q)
            IDLE: begin
                o_rdy = 1'b1;
                if (i_val) begin
                    x_d   = i_dat;
                    cnt_d = i_iter;
                    // T = 0 skips the loop entirely, which is also what keeps
                    // the counter from ever decrementing past zero.
                    state_d = (i_iter == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                o_busy      = 1'b1;
                o_mul_val   = 1'b1;
                o_iter_left = cnt_q;
                if (i_mul_rdy) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                o_busy      = 1'b1;
                o_mul_rdy   = 1'b1;
                o_iter_left = cnt_q;
                if (i_mul_val) begin
                    x_d     = i_mul_dat;
                    cnt_d   = cnt_q - ITER_W'(1);
                    state_d = (cnt_q == ITER_W'(1)) ? DONE : ISSUE;
                end
            end
            DONE: begin
                o_val = 1'b1;
                if (i_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The residue register is the single source for the result and both
    // operands, so they stay stable for as long as the state does.
    assign o_dat       = x_q;
    assign o_mul_dat_a = x_q;
    assign o_mul_dat_b = x_q;

endmodule

// File: tb/tb_mod_sq_iter_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mod_sq_iter_ctrl
//
// Directed bench for mod_sq_iter_ctrl with a behavioural modular multiplier
// (MODULUS = BLS12-381 p). Expected results and operand sequences are pushed
// to queues when a start is driven and popped when the DUT presents them.
// ----------------------------------------------------------------------------
module tb_mod_sq_iter_ctrl;

    localparam int BITS   = 392;
    localparam int ITER_W = 40;
    localparam int L      = 4;

    localparam logic [BITS-1:0] P =
        BITS'(384'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab);

    logic              clk;
    logic              rst_n;
    logic              i_val;
    logic              o_rdy;
    logic [BITS-1:0]   i_dat;
    logic [ITER_W-1:0] i_iter;
    logic              o_val;
    logic              i_rdy;
    logic [BITS-1:0]   o_dat;
    logic              o_busy;
    logic [ITER_W-1:0] o_iter_left;
    logic              o_mul_val;
    logic              i_mul_rdy;
    logic [BITS-1:0]   o_mul_dat_a;
    logic [BITS-1:0]   o_mul_dat_b;
    logic              i_mul_val;
    logic              o_mul_rdy;
    logic [BITS-1:0]   i_mul_dat;

    mod_sq_iter_ctrl #(.BITS(BITS), .ITER_W(ITER_W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_val       (i_val),
        .o_rdy       (o_rdy),
        .i_dat       (i_dat),
        .i_iter      (i_iter),
        .o_val       (o_val),
        .i_rdy       (i_rdy),
        .o_dat       (o_dat),
        .o_busy      (o_busy),
        .o_iter_left (o_iter_left),
        .o_mul_val   (o_mul_val),
        .i_mul_rdy   (i_mul_rdy),
        .o_mul_dat_a (o_mul_dat_a),
        .o_mul_dat_b (o_mul_dat_b),
        .i_mul_val   (i_mul_val),
        .o_mul_rdy   (o_mul_rdy),
        .i_mul_dat   (i_mul_dat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [BITS-1:0] obs, input logic [BITS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BITS-1:0] modmul(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        logic [2*BITS-1:0] w;
        w = {{BITS{1'b0}}, a} * {{BITS{1'b0}}, b};
        return BITS'(w % {{BITS{1'b0}}, P});
    endfunction

    // ---------------- scoreboard queues ----------------
    logic [BITS-1:0]   exp_res_q[$];
    logic [BITS-1:0]   exp_op_q[$];
    logic [ITER_W-1:0] exp_iter_q[$];

    // ---------------- behavioural multiplier ----------------
    logic            mul_rdy_drv;
    logic            rand_bp;
    logic            bp_bit;
    logic            spur;
    logic            m_busy;
    int              m_cnt;
    logic [BITS-1:0] m_res;
    int              mul_txn;

    assign i_mul_rdy = rand_bp ? bp_bit : mul_rdy_drv;
    assign i_mul_val = spur | (m_busy && m_cnt == 0);
    assign i_mul_dat = spur ? BITS'(16'hDEAD) : m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_res  <= '0;
        end else if (m_busy) begin
            if (m_cnt != 0) m_cnt <= m_cnt - 1;
            else if (o_mul_rdy) m_busy <= 1'b0;
        end else if (o_mul_val && i_mul_rdy) begin
            m_busy <= 1'b1;
            m_cnt  <= L;
            m_res  <= modmul(o_mul_dat_a, o_mul_dat_b);
        end
    end

    always @(posedge clk) begin
        #1;
        bp_bit = 1'($urandom_range(0, 1));
    end

    // ---------------- negedge monitor ----------------
    logic            prev_stall = 1'b0;
    logic [BITS-1:0] prev_a     = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_val && i_rdy) begin
                if (exp_res_q.size() == 0) check("result_unexpected", 1'b1, 1'b0);
                else check("result", o_dat, exp_res_q.pop_front());
            end
            if (o_mul_val && i_mul_rdy) begin
                mul_txn++;
                check("op_a_eq_b", o_mul_dat_b, o_mul_dat_a);
                if (exp_op_q.size() == 0) check("op_unexpected", 1'b1, 1'b0);
                else begin
                    check("op_a", o_mul_dat_a, exp_op_q.pop_front());
                    check("iter_left", BITS'(o_iter_left), BITS'(exp_iter_q.pop_front()));
                end
            end
            if (prev_stall && o_mul_val) check("op_stable", o_mul_dat_a, prev_a);
            prev_stall = o_mul_val && !i_mul_rdy;
            prev_a     = o_mul_dat_a;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [BITS-1:0] x, input int t);
        logic [BITS-1:0] v;
        int n;
        n = 0;
        while (!o_rdy && n < 50) begin
            tick();
            n++;
        end
        if (!o_rdy) check("start_timeout", 1'b0, 1'b1);
        v = x;
        for (int k = 0; k < t; k++) begin
            exp_op_q.push_back(v);
            exp_iter_q.push_back(ITER_W'(t - k));
            v = modmul(v, v);
        end
        exp_res_q.push_back(v);
        i_dat  = x;
        i_iter = ITER_W'(t);
        i_val  = 1'b1;
        tick();
        i_val  = 1'b0;
        i_dat  = '0;
    endtask

    // Counts negedges after the accept edge until o_val is seen high.
    task automatic wait_val(input int max, output int n);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (o_val) break;
            if (n >= max) begin
                check("val_timeout", 1'b0, 1'b1);
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdy"},      o_rdy, 1'b1);
        check({tag, "_val"},      o_val, 1'b0);
        check({tag, "_busy"},     o_busy, 1'b0);
        check({tag, "_mul_val"},  o_mul_val, 1'b0);
        check({tag, "_mul_rdy"},  o_mul_rdy, 1'b0);
        check({tag, "_iter"},     BITS'(o_iter_left), '0);
        check({tag, "_dat"},      o_dat, '0);
        check({tag, "_mul_a"},    o_mul_dat_a, '0);
        check({tag, "_mul_b"},    o_mul_dat_b, '0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat;
        int base;
        int n;
        rst_n       = 1'b0;
        i_val       = 1'b0;
        i_dat       = '0;
        i_iter      = '0;
        i_rdy       = 1'b1;
        mul_rdy_drv = 1'b1;
        rand_bp     = 1'b0;
        spur        = 1'b0;
        mul_txn     = 0;
        #1;
        check_reset_outputs("reset");
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Zero iterations: result one cycle after accept, no multiplier use.
        base = mul_txn;
        start(5, 0);
        wait_val(10, lat);
        check("t0_latency", BITS'(lat), BITS'(1));
        check("t0_dat", o_dat, BITS'(5));
        check("t0_no_mul", BITS'(mul_txn - base), '0);
        tick();

        // Basic loop: 2 -> 4 -> 16 -> 256, latency 3*(2+L)+1.
        base = mul_txn;
        start(2, 3);
        wait_val(100, lat);
        check("t3_latency", BITS'(lat), BITS'(19));
        check("t3_dat", o_dat, BITS'(256));
        check("t3_txn", BITS'(mul_txn - base), BITS'(3));
        tick();

        // Longer loop under random operand backpressure.
        base    = mul_txn;
        rand_bp = 1'b1;
        start(3, 5);
        wait_val(400, lat);
        rand_bp = 1'b0;
        check("t5_dat", o_dat, BITS'(64'd1853020188851841));
        check("t5_txn", BITS'(mul_txn - base), BITS'(5));
        tick();

        // Result stall: o_val/o_dat held, o_rdy low, idle right after handshake.
        i_rdy = 1'b0;
        start(2, 1);
        wait_val(50, lat);
        for (int c = 0; c < 10; c++) begin
            check("stall_val", o_val, 1'b1);
            check("stall_dat", o_dat, BITS'(4));
            check("stall_rdy", o_rdy, 1'b0);
            @(negedge clk);
        end
        tick();
        i_rdy = 1'b1;
        tick();
        check("post_hs_rdy", o_rdy, 1'b1);
        check("post_hs_val", o_val, 1'b0);

        // Spurious multiplier results in ISSUE and DONE are ignored.
        mul_rdy_drv = 1'b0;
        start(2, 2);
        spur = 1'b1;
        repeat (2) tick();
        check("spur_issue_val", o_mul_val, 1'b1);
        check("spur_issue_op", o_mul_dat_a, BITS'(2));
        spur        = 1'b0;
        mul_rdy_drv = 1'b1;
        i_rdy       = 1'b0;
        wait_val(100, lat);
        tick();
        spur = 1'b1;
        repeat (2) tick();
        spur = 1'b0;
        check("spur_done_val", o_val, 1'b1);
        check("spur_done_dat", o_dat, BITS'(16));
        i_rdy = 1'b1;
        tick();

        // Reset during WAIT of iteration 2 of 5.
        base = mul_txn;
        start(3, 5);
        n = 0;
        while (!(mul_txn - base == 2 && o_mul_rdy) && n < 200) begin
            tick();
            n++;
        end
        check("reach_wait2", o_mul_rdy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_res_q.delete();
        exp_op_q.delete();
        exp_iter_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        start(7, 1);
        wait_val(50, lat);
        check("after_rst_dat", o_dat, BITS'(49));
        repeat (2) tick();

        check("sb_drained", BITS'(exp_res_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
